snake_score_tracker: RTL
========================

// Module: snake_score_tracker
// PURPOSE
//  Parametrised BCD score keeper for the snake game. Each cycle it compares the snake-head and
//  rabbit position codes. On a valid catch it adds one to a multi-digit BCD score and pulses
//  eat_pulse. It then holds rabbit_clear high for a fixed holdoff, with a re-arm guard so that
//  one catch never counts twice. Sits between the LED movement/rabbit generators and the
//  seven-segment display driver.
// PARAMETERS
//  POS_W          8        width of pos_snake / pos_rabbit position codes
//  NUM_DIGITS     1        BCD digits in score (1..4); score wraps from all-9s to 0
//  HOLDOFF_CYCLES 1500000  clk cycles rabbit_clear stays high after a catch (>=1)
// PORTS
//  clk          in   1             system clock; all state changes on rising edge
//  rst          in   1             asynchronous, active-high reset
//  game_reset   in   1             synchronous restart: clears score/state
//  pos_snake    in   POS_W         current snake-head position code (0 = invalid/none)
//  pos_rabbit   in   POS_W         current rabbit position code (0 = no rabbit)
//  eat_pulse    out  1             1-cycle pulse per counted catch
//  rabbit_clear out  1             high during holdoff; requests new rabbit placement
//  score_bcd    out  4*NUM_DIGITS  BCD score; digit 0 in [3:0]
//  score_wrap   out  1             sticky: score has wrapped past all-9s
//  busy         out  1             high in HOLD or WAIT_REL (catches ignored)
// BEHAVIOUR
//  - Reset (rst=1, async): state ARMED. eat_pulse=0, rabbit_clear=0, score_bcd=0,
//    score_wrap=0, busy=0, holdoff counter=0.
//  - match = (pos_snake==pos_rabbit) && (pos_snake!=0) && (pos_rabbit!=0); combinational on
//    the inputs, sampled at the clk edge.
//  - FSM:
//    ARMED: match -> HOLD. Same edge: score+1, eat_pulse=1 for exactly 1 cycle,
//      rabbit_clear=1, cnt=HOLDOFF_CYCLES-1. Outputs update on the edge that samples match
//      (visible 1 cycle later).
//    HOLD: rabbit_clear=1, busy=1. cnt decrements each cycle. At cnt==0: if !match -> ARMED,
//      rabbit_clear=0; else -> WAIT_REL, rabbit_clear=0. rabbit_clear width is exactly
//      HOLDOFF_CYCLES cycles.
//    WAIT_REL: busy=1, no counting; -> ARMED on the first cycle with !match. Prevents a
//      stale equal pair being recounted.
//  - BCD increment: digit 0 +1. Any digit at 9 rolls to 0 and carries into the next digit.
//    Carry out of the top digit: all digits become 0 and score_wrap is set (sticky until rst
//    or game_reset).
//  - game_reset=1: same clear as rst (except the CONFIGURATION exception below), applied on
//    the clk edge. It takes priority over a simultaneous match: no increment, no eat_pulse.
//  - rst asserted mid-HOLD: immediate clear to ARMED; rabbit_clear drops asynchronously.
//  - Input changes during HOLD or WAIT_REL never alter the score.
//  - Counter width = $clog2(HOLDOFF_CYCLES+1). HOLDOFF_CYCLES=1 gives a 1-cycle rabbit_clear.
// CONFIGURATION
//  SNAKE_HISCORE_EN defined:
//    - Adds output hi_score [4*NUM_DIGITS-1:0], reset to 0 by rst only (game_reset keeps it).
//    - On each counted catch, if the new score_bcd > hi_score, hi_score takes the new value
//      on the same edge.
//    - A wrapped score never lowers hi_score.
//  SNAKE_HISCORE_EN undefined: no hi_score port and no related logic.
// TESTING  (HOLDOFF_CYCLES=4 unless noted)
//  1. rst pulse, then pos_snake=8'h10, pos_rabbit=8'h10 for 1 cycle -> eat_pulse high 1 cycle,
//     score_bcd=1, rabbit_clear high 4 cycles, then ARMED.
//  2. Positions held equal for 10 cycles -> exactly one increment; busy stays high until
//     inputs differ.
//  3. Both positions 0 and equal -> no catch; score unchanged.
//  4. NUM_DIGITS=2, 99 catches, then 1 more -> score_bcd=8'h00, score_wrap=1. Check that
//     catch 10 gives 8'h10.
//  5. game_reset and a match on the same edge -> score 0, eat_pulse 0, state ARMED.
//  6. rst asserted mid-HOLD (cycle 2) -> rabbit_clear=0 and score=0 immediately, without
//     waiting for clk. With SNAKE_HISCORE_EN: score 3 then game_reset -> hi_score stays 3.

Source files
------------

// File: rtl/snake_score_tracker_if.sv
// Bundles the game-side signals of snake_score_tracker: position inputs,
// synchronous restart, and score/status outputs.
// Optional: SNAKE_HISCORE_EN adds the hi_score output.
interface snake_score_tracker_if #(
  parameter int POS_W      = 8,
  parameter int NUM_DIGITS = 1
);
  logic                    game_reset;
  logic [POS_W-1:0]        pos_snake;
  logic [POS_W-1:0]        pos_rabbit;
  logic                    eat_pulse;
  logic                    rabbit_clear;
  logic [4*NUM_DIGITS-1:0] score_bcd;
  logic                    score_wrap;
  logic                    busy;
`ifdef SNAKE_HISCORE_EN
  logic [4*NUM_DIGITS-1:0] hi_score;

  modport master (
    output game_reset, pos_snake, pos_rabbit,
    input  eat_pulse, rabbit_clear, score_bcd, score_wrap, busy, hi_score
  );
  modport slave (
    input  game_reset, pos_snake, pos_rabbit,
    output eat_pulse, rabbit_clear, score_bcd, score_wrap, busy, hi_score
  );
`else
  modport master (
    output game_reset, pos_snake, pos_rabbit,
    input  eat_pulse, rabbit_clear, score_bcd, score_wrap, busy
  );
  modport slave (
    input  game_reset, pos_snake, pos_rabbit,
    output eat_pulse, rabbit_clear, score_bcd, score_wrap, busy
  );
`endif
endinterface

// File: rtl/snake_score_tracker.sv
// snake_score_tracker: detects snake-head / rabbit coincidence, adds one to a
// multi-digit BCD score per catch, then holds rabbit_clear for HOLDOFF_CYCLES
// and waits for the positions to separate before re-arming.
// Optional: SNAKE_HISCORE_EN adds a hi_score register kept across game_reset.
module snake_score_tracker #(
  parameter int POS_W          = 8,
  parameter int NUM_DIGITS     = 1,
  parameter int HOLDOFF_CYCLES = 1500000
) (
  input  logic                  clk,
  input  logic                  rst,
  snake_score_tracker_if.slave  bus
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {ARMED, HOLD, WAIT_REL} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_score, w_score_nxt, w_score_inc;
  logic            r_wrap, w_wrap_nxt;
  logic            r_eat, w_eat_nxt;
  logic            w_carry;
  logic            w_match;
`ifdef SNAKE_HISCORE_EN
  logic [SW-1:0]   r_hi, w_hi_nxt;
`endif

  assign w_match = (bus.pos_snake == bus.pos_rabbit) &&
                   (bus.pos_snake != '0) && (bus.pos_rabbit != '0);

  // BCD +1 with ripple carry; w_carry left high means the top digit overflowed
  always_comb begin
    w_score_inc = '0;
    w_carry     = 1'b1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (w_carry) begin
        if (r_score[4*d +: 4] == 4'd9) begin
          w_score_inc[4*d +: 4] = '0;
        end else begin
          w_score_inc[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end else begin
        w_score_inc[4*d +: 4] = r_score[4*d +: 4];
      end
    end
  end

  // Next-state and next-value logic; game_reset overrides any catch
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_score_nxt = r_score;
    w_wrap_nxt  = r_wrap;
    w_eat_nxt   = 1'b0;
`ifdef SNAKE_HISCORE_EN
    w_hi_nxt    = r_hi;
`endif
    if (bus.game_reset) begin
      w_state_nxt = ARMED;
      w_cnt_nxt   = '0;
      w_score_nxt = '0;
      w_wrap_nxt  = 1'b0;
    end else begin
      case (r_state)
        ARMED: begin
          if (w_match) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = CW'(HOLDOFF_CYCLES - 1);
            w_eat_nxt   = 1'b1;
            w_score_nxt = w_score_inc;
            if (w_carry) w_wrap_nxt = 1'b1;
`ifdef SNAKE_HISCORE_EN
            if (w_score_inc > r_hi) w_hi_nxt = w_score_inc;
`endif
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            w_state_nxt = w_match ? WAIT_REL : ARMED;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        WAIT_REL: begin
          if (!w_match) w_state_nxt = ARMED;
        end
        default: w_state_nxt = ARMED;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARMED;
      r_cnt   <= '0;
      r_score <= '0;
      r_wrap  <= 1'b0;
      r_eat   <= 1'b0;
`ifdef SNAKE_HISCORE_EN
      r_hi    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_score <= w_score_nxt;
      r_wrap  <= w_wrap_nxt;
      r_eat   <= w_eat_nxt;
`ifdef SNAKE_HISCORE_EN
      r_hi    <= w_hi_nxt;
`endif
    end
  end

  // rabbit_clear/busy decode straight from state so rst drops them at once
  assign bus.eat_pulse    = r_eat;
  assign bus.rabbit_clear = (r_state == HOLD);
  assign bus.busy         = (r_state != ARMED);
  assign bus.score_bcd    = r_score;
  assign bus.score_wrap   = r_wrap;
`ifdef SNAKE_HISCORE_EN
  assign bus.hi_score     = r_hi;
`endif

endmodule
